// File: rtl/uart_pkg.sv
// uart_pkg: shared uart_wb8 register map, status bit indices and scheduler FSM encoding
package uart_pkg;
  localparam logic [1:0] DEF_STATUS_ADR = 2'd1;
  localparam logic [1:0] DEF_DATA_ADR = 2'd0;
  localparam int RX_RDY = 0;
  localparam int TX_BUSY = 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POLL = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RXREAD = 2'd3;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8-bit synchronous FIFO with wrap-bit pointers, 2**AW entries
module uart_tx_fifo #(
  parameter int AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  logic [7:0] mem [2**AW];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin two-requester TX scheduler and Wishbone polling master for uart_wb8; UART_TX_SCHED_RX_EN adds RX draining
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter logic [1:0] STATUS_ADR = DEF_STATUS_ADR,
  parameter logic [1:0] DATA_ADR = DEF_DATA_ADR,
  parameter logic [3:0] ACK_TMO = 4'd15
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [7:0] I_req0_data,
  input  logic       I_req0_valid,
  output logic       O_req0_ready,
  input  logic [7:0] I_req1_data,
  input  logic       I_req1_valid,
  output logic       O_req1_ready,
  output logic [1:0] O_adr,
  output logic [7:0] O_dat,
  input  logic [7:0] I_dat,
  output logic       O_stb,
  output logic       O_we,
  input  logic       I_ack,
  output logic       O_busy,
  output logic       O_err
`ifdef UART_TX_SCHED_RX_EN
  ,
  output logic [7:0] O_rx_data,
  output logic       O_rx_valid,
  input  logic       I_rx_ready
`endif
);
  logic [1:0] state;
  logic [3:0] tmo;
  logic pri, full, empty, gnt0, gnt1, pop, rx_go;
  logic [7:0] head;
  // pri set means requester 1 wins a tie
  always_comb begin
    gnt0 = !full && I_req0_valid && (!I_req1_valid || !pri);
    gnt1 = !full && I_req1_valid && (!I_req0_valid || pri);
    pop = state == ST_WRITE && O_stb && I_ack;
  end
  assign O_req0_ready = gnt0;
  assign O_req1_ready = gnt1;
  assign O_busy = !empty || state != ST_IDLE;
`ifdef UART_TX_SCHED_RX_EN
  assign rx_go = I_dat[RX_RDY] && !O_rx_valid;
`else
  logic unused_dat;
  assign rx_go = 1'b0;
  assign unused_dat = ^{I_dat[7:2], I_dat[RX_RDY]};
`endif
  uart_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk(CLK_I),
    .rst(RST_I),
    .push(gnt0 || gnt1),
    .din(gnt1 ? I_req1_data : I_req0_data),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  // WRITE/RXREAD enter with stb low so a strobe never directly follows an ack
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      state <= ST_IDLE;
      tmo <= '0;
      pri <= 1'b0;
      O_stb <= 1'b0;
      O_we <= 1'b0;
      O_adr <= '0;
      O_dat <= '0;
      O_err <= 1'b0;
`ifdef UART_TX_SCHED_RX_EN
      O_rx_data <= '0;
      O_rx_valid <= 1'b0;
`endif
    end else begin
      if (gnt0 || gnt1) pri <= gnt0;
`ifdef UART_TX_SCHED_RX_EN
      if (O_rx_valid && I_rx_ready) O_rx_valid <= 1'b0;
`endif
      if (O_stb && !I_ack) begin
        tmo <= tmo + 4'd1;
        if (tmo + 4'd1 == ACK_TMO) begin
          O_stb <= 1'b0;
          O_we <= 1'b0;
          O_err <= 1'b1;
          state <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE:
            if (!empty) begin
              O_stb <= 1'b1;
              O_we <= 1'b0;
              O_adr <= STATUS_ADR;
              tmo <= '0;
              state <= ST_POLL;
            end
          ST_POLL: begin
            O_stb <= 1'b0;
            state <= rx_go ? ST_RXREAD : I_dat[TX_BUSY] ? ST_IDLE : ST_WRITE;
          end
          ST_WRITE:
            if (!O_stb) begin
              O_stb <= 1'b1;
              O_we <= 1'b1;
              O_adr <= DATA_ADR;
              O_dat <= head;
              tmo <= '0;
            end else begin
              O_stb <= 1'b0;
              O_we <= 1'b0;
              state <= ST_IDLE;
            end
          ST_RXREAD:
`ifdef UART_TX_SCHED_RX_EN
            if (!O_stb) begin
              O_stb <= 1'b1;
              O_we <= 1'b0;
              O_adr <= DATA_ADR;
              tmo <= '0;
            end else begin
              O_stb <= 1'b0;
              O_rx_data <= I_dat;
              O_rx_valid <= 1'b1;
              state <= ST_IDLE;
            end
`else
            state <= ST_IDLE;
`endif
        endcase
      end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized self-checking bench for uart_tx_sched with a uart_wb8 stub and scoreboard
module tb_uart_tx_sched;
  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  logic [7:0] I_req0_data = '0, I_req1_data = '0;
  logic I_req0_valid = 1'b0, I_req1_valid = 1'b0;
  logic O_req0_ready, O_req1_ready;
  logic [1:0] O_adr;
  logic [7:0] O_dat, I_dat;
  logic O_stb, O_we, I_ack, O_busy, O_err;
  logic ack_en = 1'b1;
  logic rx_pend = 1'b0;
  logic [7:0] rx_byte = 8'h41;
  int busy_left = 0;
  int rd_cnt = 0, dr_cnt = 0;
  logic prev_ack = 1'b0, gap_viol = 1'b0;
  logic [7:0] wr_q[$], src0[$], src1[$], exp_q[$];
  int n_run = 0, n_fail = 0;
`ifdef UART_TX_SCHED_RX_EN
  logic [7:0] O_rx_data;
  logic O_rx_valid;
  logic I_rx_ready = 1'b0;
`endif

  always #5 CLK_I = ~CLK_I;

  assign I_ack = O_stb && ack_en;
  assign I_dat = (O_adr == 2'd1) ? {6'd0, busy_left > 0, rx_pend} : rx_byte;

  uart_tx_sched dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .I_req0_data(I_req0_data), .I_req0_valid(I_req0_valid), .O_req0_ready(O_req0_ready),
    .I_req1_data(I_req1_data), .I_req1_valid(I_req1_valid), .O_req1_ready(O_req1_ready),
    .O_adr(O_adr), .O_dat(O_dat), .I_dat(I_dat), .O_stb(O_stb), .O_we(O_we),
    .I_ack(I_ack), .O_busy(O_busy), .O_err(O_err)
`ifdef UART_TX_SCHED_RX_EN
    , .O_rx_data(O_rx_data), .O_rx_valid(O_rx_valid), .I_rx_ready(I_rx_ready)
`endif
  );

  // UART stub log: completed writes, status reads, data reads, strobe-after-ack violations
  always @(posedge CLK_I) begin
    prev_ack <= O_stb && I_ack;
    if (prev_ack && O_stb) gap_viol <= 1'b1;
    if (O_stb && I_ack) begin
      if (O_we) wr_q.push_back(O_dat);
      else if (O_adr == 2'd1) begin
        rd_cnt <= rd_cnt + 1;
        if (busy_left > 0) busy_left <= busy_left - 1;
      end else begin
        dr_cnt <= dr_cnt + 1;
        rx_pend <= 1'b0;
      end
    end
  end

  function automatic bit same(input logic [7:0] a[$], input logic [7:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_log();
    wr_q.delete();
    rd_cnt = 0;
    dr_cnt = 0;
  endtask

  task automatic apply_reset();
    RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b0;
    clear_log();
  endtask

  // drives src0/src1 as valid/ready streams; with chk, checks each cycle's grants against the arbitration rules
  task automatic stream(input int pv, input bit chk);
    int i0 = 0, i1 = 0, b = 4000, pushed = 0, occ;
    bit pref0 = 1'b1, r0, r1, e0, e1;
    while ((i0 < src0.size() || i1 < src1.size()) && b > 0) begin
      @(negedge CLK_I);
      I_req0_valid = i0 < src0.size() && $urandom_range(99) < pv;
      I_req0_data = i0 < src0.size() ? src0[i0] : 8'h00;
      I_req1_valid = i1 < src1.size() && $urandom_range(99) < pv;
      I_req1_data = i1 < src1.size() ? src1[i1] : 8'h00;
      #1;
      r0 = O_req0_ready;
      r1 = O_req1_ready;
      if (chk) begin
        occ = pushed - wr_q.size();
        e0 = occ < 8 && I_req0_valid && (!I_req1_valid || pref0);
        e1 = occ < 8 && I_req1_valid && (!I_req0_valid || !pref0);
        n_run++;
        if ({r0, r1} !== {e0, e1}) begin
          n_fail++;
          $display("FAIL arb: readies %b%b required %b%b (occ %0d)", r0, r1, e0, e1, occ);
        end
      end
      if (r0) begin i0++; pushed++; pref0 = 1'b0; end
      if (r1) begin i1++; pushed++; pref0 = 1'b1; end
      b--;
    end
    @(negedge CLK_I);
    I_req0_valid = 1'b0;
    I_req1_valid = 1'b0;
    n_run++;
    if (b == 0) begin
      n_fail++;
      $display("FAIL stream_budget: accepted %0d/%0d and %0d/%0d, required all", i0, src0.size(), i1, src1.size());
    end
  endtask

  task automatic wait_idle(input string tag);
    int b = 3000;
    @(negedge CLK_I);
    while (O_busy && b > 0) begin
      @(negedge CLK_I);
      b--;
    end
    n_run++;
    if (O_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy %b after budget, required 0", tag, O_busy);
    end
    repeat (3) @(negedge CLK_I);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK_I);
    n_run++;
    if ({O_stb, O_we, O_adr, O_dat} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_wb: stb %b we %b adr %h dat %h, required all 0", O_stb, O_we, O_adr, O_dat);
    end
    RST_I = 1'b0;
    @(negedge CLK_I);
    n_run++;
    if ({O_req0_ready, O_req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: %b%b required 00", O_req0_ready, O_req1_ready);
    end
    n_run++;
    if ({O_busy, O_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_status: busy %b err %b required 0 0", O_busy, O_err);
    end
  endtask

  task automatic test_interleave();
    clear_log();
    src0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    src1 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    exp_q = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
    stream(100, 1'b0);
    wait_idle("interleave");
    n_run++;
    if (!same(wr_q, exp_q)) begin
      n_fail++;
      $display("FAIL interleave_order: got %p required %p", wr_q, exp_q);
    end
    n_run++;
    if (rd_cnt !== 8) begin
      n_fail++;
      $display("FAIL interleave_polls: %0d status reads, required 8", rd_cnt);
    end
  endtask

  task automatic test_single();
    clear_log();
    @(negedge CLK_I);
    I_req0_valid = 1'b1;
    I_req0_data = 8'h54;
    #1;
    n_run++;
    if (O_req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: %b required 1", O_req0_ready);
    end
    @(posedge CLK_I);
    @(negedge CLK_I);
    I_req0_valid = 1'b0;
    @(posedge CLK_I);
    @(negedge CLK_I);
    n_run++;
    if ({O_stb, O_we, O_adr} !== 4'b1001) begin
      n_fail++;
      $display("FAIL single_poll: stb %b we %b adr %h, required 1 0 1", O_stb, O_we, O_adr);
    end
    @(posedge CLK_I);
    @(negedge CLK_I);
    n_run++;
    if (O_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL single_gap: stb %b required 0", O_stb);
    end
    @(posedge CLK_I);
    @(negedge CLK_I);
    n_run++;
    if ({O_stb, O_we, O_adr, O_dat} !== {4'b1100, 8'h54}) begin
      n_fail++;
      $display("FAIL single_write: stb %b we %b adr %h dat %h, required 1 1 0 54", O_stb, O_we, O_adr, O_dat);
    end
    wait_idle("single");
    exp_q = '{8'h54};
    n_run++;
    if (!same(wr_q, exp_q) || rd_cnt !== 1) begin
      n_fail++;
      $display("FAIL single_txn: writes %p reads %0d, required %p and 1", wr_q, rd_cnt, exp_q);
    end
  endtask

  task automatic test_busy_poll();
    clear_log();
    busy_left = 3;
    src0 = '{8'h33};
    src1 = {};
    stream(100, 1'b0);
    wait_idle("busy");
    exp_q = '{8'h33};
    n_run++;
    if (rd_cnt !== 4) begin
      n_fail++;
      $display("FAIL busy_polls: %0d status reads, required 4", rd_cnt);
    end
    n_run++;
    if (!same(wr_q, exp_q)) begin
      n_fail++;
      $display("FAIL busy_write: got %p required %p", wr_q, exp_q);
    end
  endtask

  task automatic test_random();
    logic [7:0] g0[$], g1[$];
    apply_reset();
    src0 = {};
    src1 = {};
    for (int i = 0; i < 30; i++) begin
      src0.push_back(8'($urandom_range(0, 127)));
      src1.push_back(8'($urandom_range(128, 255)));
    end
    busy_left = $urandom_range(0, 3);
    stream(60, 1'b1);
    wait_idle("random");
    foreach (wr_q[i]) if (wr_q[i][7]) g1.push_back(wr_q[i]); else g0.push_back(wr_q[i]);
    n_run++;
    if (!same(g0, src0)) begin
      n_fail++;
      $display("FAIL random_req0: got %p required %p", g0, src0);
    end
    n_run++;
    if (!same(g1, src1)) begin
      n_fail++;
      $display("FAIL random_req1: got %p required %p", g1, src1);
    end
  endtask

  task automatic test_timeout();
    int b = 60;
    clear_log();
    ack_en = 1'b0;
    src0 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    src1 = {};
    stream(100, 1'b0);
    I_req0_valid = 1'b1;
    I_req0_data = 8'h18;
    #1;
    n_run++;
    if ({O_req0_ready, O_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_ready: ready %b err %b, required 0 0", O_req0_ready, O_err);
    end
    @(negedge CLK_I);
    I_req0_valid = 1'b0;
    while (!O_err && b > 0) begin
      @(negedge CLK_I);
      b--;
    end
    n_run++;
    if ({O_err, O_stb} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout: err %b stb %b, required 1 0", O_err, O_stb);
    end
    ack_en = 1'b1;
    wait_idle("timeout");
    n_run++;
    if (!same(wr_q, src0)) begin
      n_fail++;
      $display("FAIL retry_writes: got %p required %p", wr_q, src0);
    end
    n_run++;
    if (O_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err %b required 1", O_err);
    end
  endtask

  task automatic test_reset_mid();
    int b = 50, n_wb;
    bit saw = 1'b0;
    clear_log();
    src0 = '{8'h61, 8'h62, 8'h63};
    src1 = {};
    stream(100, 1'b0);
    while (!(O_stb && O_we) && b > 0) begin
      @(negedge CLK_I);
      b--;
    end
    n_run++;
    if ({O_stb, O_we} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_write: stb %b we %b, required 1 1", O_stb, O_we);
    end
    RST_I = 1'b1;
    #1;
    n_run++;
    if ({O_stb, O_busy, O_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset: stb %b busy %b err %b, required 0 0 0", O_stb, O_busy, O_err);
    end
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b0;
    n_wb = wr_q.size() + rd_cnt;
    repeat (20) begin
      @(negedge CLK_I);
      saw |= O_stb;
    end
    n_run++;
    if (saw || wr_q.size() + rd_cnt != n_wb || O_busy) begin
      n_fail++;
      $display("FAIL post_reset: stb seen %b txns %0d->%0d busy %b, required none", saw, n_wb, wr_q.size() + rd_cnt, O_busy);
    end
  endtask

`ifdef UART_TX_SCHED_RX_EN
  task automatic test_rx();
    int b = 60;
    clear_log();
    rx_pend = 1'b1;
    src0 = '{8'h55};
    src1 = {};
    stream(100, 1'b0);
    while (!O_rx_valid && b > 0) begin
      @(negedge CLK_I);
      b--;
    end
    repeat (5) @(negedge CLK_I);
    n_run++;
    if ({O_rx_valid, O_rx_data} !== {1'b1, 8'h41}) begin
      n_fail++;
      $display("FAIL rx_hold: valid %b data %h, required 1 41", O_rx_valid, O_rx_data);
    end
    I_rx_ready = 1'b1;
    @(negedge CLK_I);
    I_rx_ready = 1'b0;
    n_run++;
    if (O_rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_release: valid %b required 0", O_rx_valid);
    end
    wait_idle("rx");
    exp_q = '{8'h55};
    n_run++;
    if (!same(wr_q, exp_q) || dr_cnt !== 1) begin
      n_fail++;
      $display("FAIL rx_tx: writes %p data reads %0d, required %p and 1", wr_q, dr_cnt, exp_q);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_interleave();
    test_single();
    test_busy_poll();
    test_random();
    test_timeout();
    test_reset_mid();
`ifdef UART_TX_SCHED_RX_EN
    test_rx();
`endif
    n_run++;
    if (gap_viol) begin
      n_fail++;
      $display("FAIL stb_gap: strobe seen right after ack %b, required 0", gap_viol);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
